fc_84_sched: RTL
================

# fc_84_sched

Sequencer that time-shares one `fc_84` dot-product instance across the NUM_NEURONS output neurons of the final LeNet-5 classifier layer (84 inputs to 10 classes). It latches the 84-element feature vector and, per neuron, fetches that neuron's weight row and bias from a synchronous weight ROM. It drives the `fc_84` operands from registers, captures the result, and streams per-class scores out over a valid/ready handshake while tracking the argmax class.

## Interface
Parameters:
- BIT_WIDTH, 32, width of one input, weight and bias element
- OUT_WIDTH, 64, width of an `fc_84` result and of res_data
- NUM_NEURONS, 10, output neurons sequenced per frame (1..16)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin frame; accepted only in IDLE
- in_vec  in  BIT_WIDTH*84  feature vector; sampled on start acceptance
- busy  out  1  high from acceptance until the DONE cycle inclusive
- wt_rd  out  1  weight-ROM read strobe
- wt_addr  out  4  neuron index to read
- wt_data  in  BIT_WIDTH*84  weight row; valid the cycle after wt_rd
- bias_data  in  BIT_WIDTH  bias; valid the cycle after wt_rd
- fc_in  out  BIT_WIDTH*84  to `fc_84` in (registered latched vector)
- fc_weights  out  BIT_WIDTH*84  to `fc_84` in_weights (registered)
- fc_bias  out  BIT_WIDTH  to `fc_84` bias (registered)
- fc_out  in  OUT_WIDTH  `fc_84` out (combinational from fc_* operands)
- res_valid  out  1  score available
- res_ready  in  1  consumer accepts score
- res_data  out  OUT_WIDTH  signed score of neuron res_idx
- res_idx  out  4  neuron index of res_data
- done  out  1  one-cycle pulse after the last score handshake
- argmax  out  4  index of the maximum score
- argmax_valid  out  1  argmax is valid for the last completed frame

## Operation
- States: IDLE, FETCH, LOAD, CALC, OUT, DONE. Neuron counter k, 4 bits.
- IDLE: on start=1, latch in_vec into fc_in, clear k, clear argmax_valid, set busy, go to FETCH. start in any other state is ignored.
- FETCH: wt_rd=1, wt_addr=k, go to LOAD. wt_rd is 0 in every other state.
- LOAD: register wt_data into fc_weights and bias_data into fc_bias, go to CALC.
- CALC: fc_out is settled. Register it into res_data and k into res_idx.
  - If k==0, or fc_out > best (signed, strict), set best=fc_out and argmax=k. Ties keep the lower index.
  - Go to OUT.
- OUT: res_valid=1. res_data/res_idx are held stable until res_ready=1.
  - On the handshake: if k==NUM_NEURONS-1, go to DONE; otherwise increment k and go to FETCH.
- DONE: done=1, argmax_valid set, busy still 1, then go to IDLE.
- argmax and argmax_valid hold until the next start is accepted. The best register is OUT_WIDTH signed.
- fc_* operands hold their last values when not being loaded.
- No arithmetic is performed here beyond the signed compare; the sum width is owned by `fc_84`.
- rst at any cycle: return to IDLE; the frame in flight is discarded and no done pulse is issued.

## Timing
- Reset values: every output is 0 (busy, wt_rd, wt_addr, res_valid, res_data, res_idx, done, argmax, argmax_valid, fc_in, fc_weights, fc_bias). Internal k and best are 0.
- Start accepted at cycle T:
  - FETCH of neuron k at T+1+4k with res_ready held high.
  - res_valid for neuron k at T+4+4k.
  - done and argmax_valid rise at T+4*NUM_NEURONS+1 (T+41 for the default).
  - busy falls the following cycle.
- Each cycle with res_valid=1 and res_ready=0 adds one cycle to the frame; no score is lost or duplicated.
- The earliest next start is accepted the cycle after DONE (back in IDLE).
- The ROM is assumed 1-cycle latency with no stall.

## Test plan
- Reset then idle: with rst high for 2 cycles, every output is 0. With start low, it stays so, and wt_rd never asserts.
- Basic frame: in_vec all 1; row k has all weights = k+1 and bias = k. res_ready=1.
  - Expected scores: 84(k+1)+k, streamed for k=0..9 at cycles T+4, T+8, ... T+40.
  - done at T+41; argmax=9 with argmax_valid=1.
- Backpressure: res_ready low for 3 cycles on neuron 4.
  - res_valid, res_data and res_idx=4 stay stable throughout.
  - The frame completes 3 cycles late with all 10 scores in order.
- Signed/tie argmax: scores -5, 7, 7, -100, then -1 for the rest. argmax=1, since the tie keeps the lower index.
- Start ignored while busy: pulse start with a different in_vec at T+10.
  - The scores match the original vector.
  - Exactly one done pulse is issued.
- Mid-frame reset: assert rst during neuron 6's OUT state.
  - Next cycle: IDLE with all outputs 0, and no done pulse.
  - A subsequent start then runs a full, correct frame.

Source files
------------

// File: rtl/fc_84_sched_if.sv
// Bundle of the fc_84_sched control, ROM, operand and result signals.
// Latency: n/a (wiring only).
// Backpressure: res_valid/res_ready handshake on the score stream.
interface fc_84_sched_if #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64
);
  // frame control
  logic                     start;
  logic [BIT_WIDTH*84-1:0]  in_vec;
  logic                     busy;
  logic                     done;
  // weight ROM
  logic                     wt_rd;
  logic [3:0]               wt_addr;
  logic [BIT_WIDTH*84-1:0]  wt_data;
  logic [BIT_WIDTH-1:0]     bias_data;
  // fc_84 operands and result
  logic [BIT_WIDTH*84-1:0]  fc_in;
  logic [BIT_WIDTH*84-1:0]  fc_weights;
  logic [BIT_WIDTH-1:0]     fc_bias;
  logic [OUT_WIDTH-1:0]     fc_out;
  // score stream and argmax
  logic                     res_valid;
  logic                     res_ready;
  logic [OUT_WIDTH-1:0]     res_data;
  logic [3:0]               res_idx;
  logic [3:0]               argmax;
  logic                     argmax_valid;

  // environment side: drives start, ROM data, fc_84 result and consumer ready
  modport master (
    output start, in_vec, wt_data, bias_data, fc_out, res_ready,
    input  busy, done, wt_rd, wt_addr, fc_in, fc_weights, fc_bias,
           res_valid, res_data, res_idx, argmax, argmax_valid
  );

  // sequencer side
  modport slave (
    input  start, in_vec, wt_data, bias_data, fc_out, res_ready,
    output busy, done, wt_rd, wt_addr, fc_in, fc_weights, fc_bias,
           res_valid, res_data, res_idx, argmax, argmax_valid
  );
endinterface

// File: rtl/fc_84_sched.sv
// Time-shares one fc_84 dot product over NUM_NEURONS neurons, streams scores, tracks argmax.
// Latency: 4 cycles per neuron (FETCH, LOAD, CALC, OUT) plus 1 DONE cycle per frame.
// Backpressure: OUT holds res_data/res_idx until res_ready; each stalled cycle delays the frame.
module fc_84_sched #(
  parameter int BIT_WIDTH   = 32,
  parameter int OUT_WIDTH   = 64,
  parameter int NUM_NEURONS = 10
) (
  input  logic         clk,
  input  logic         rst,
  fc_84_sched_if.slave sched_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_CALC  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [3:0] LAST_K = 4'(NUM_NEURONS - 1);

  state_e                   state_q;
  logic [3:0]               k_q;
  logic signed [OUT_WIDTH-1:0] best_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     wt_rd_q;
  logic [3:0]               wt_addr_q;
  logic [BIT_WIDTH*84-1:0]  fc_in_q;
  logic [BIT_WIDTH*84-1:0]  fc_weights_q;
  logic [BIT_WIDTH-1:0]     fc_bias_q;
  logic                     res_valid_q;
  logic [OUT_WIDTH-1:0]     res_data_q;
  logic [3:0]               res_idx_q;
  logic [3:0]               argmax_q;
  logic                     argmax_valid_q;

  // New best when it is the first neuron of the frame or strictly greater; ties keep lower index.
  logic new_best;
  always_comb begin
    new_best = (k_q == 4'd0) || ($signed(sched_if.fc_out) > best_q);
  end

  // Frame sequencer; every output is a register written on the transition into its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      best_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      wt_rd_q        <= 1'b0;
      wt_addr_q      <= '0;
      fc_in_q        <= '0;
      fc_weights_q   <= '0;
      fc_bias_q      <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_idx_q      <= '0;
      argmax_q       <= '0;
      argmax_valid_q <= 1'b0;
    end else begin
      wt_rd_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sched_if.start) begin
            fc_in_q        <= sched_if.in_vec;
            k_q            <= '0;
            argmax_valid_q <= 1'b0;
            busy_q         <= 1'b1;
            wt_rd_q        <= 1'b1;
            wt_addr_q      <= '0;
            state_q        <= S_FETCH;
          end
        end
        S_FETCH: begin
          // ROM returns the row on the next cycle
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          fc_weights_q <= sched_if.wt_data;
          fc_bias_q    <= sched_if.bias_data;
          state_q      <= S_CALC;
        end
        S_CALC: begin
          // fc_84 has had a full cycle to settle on the registered operands
          res_data_q  <= sched_if.fc_out;
          res_idx_q   <= k_q;
          res_valid_q <= 1'b1;
          if (new_best) begin
            best_q   <= $signed(sched_if.fc_out);
            argmax_q <= k_q;
          end
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (sched_if.res_ready) begin
            res_valid_q <= 1'b0;
            if (k_q == LAST_K) begin
              done_q         <= 1'b1;
              argmax_valid_q <= 1'b1;
              state_q        <= S_DONE;
            end else begin
              k_q       <= k_q + 4'd1;
              wt_rd_q   <= 1'b1;
              wt_addr_q <= k_q + 4'd1;
              state_q   <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sched_if.busy         = busy_q;
  assign sched_if.done         = done_q;
  assign sched_if.wt_rd        = wt_rd_q;
  assign sched_if.wt_addr      = wt_addr_q;
  assign sched_if.fc_in        = fc_in_q;
  assign sched_if.fc_weights   = fc_weights_q;
  assign sched_if.fc_bias      = fc_bias_q;
  assign sched_if.res_valid    = res_valid_q;
  assign sched_if.res_data     = res_data_q;
  assign sched_if.res_idx      = res_idx_q;
  assign sched_if.argmax       = argmax_q;
  assign sched_if.argmax_valid = argmax_valid_q;

endmodule
